// File: rtl/dmp_pkg.sv
// Shared encodings for the data memory port: access sizes and FSM states.
package dmp_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } dmpState_t;

endpackage

// File: rtl/data_mem_port_if.sv
// Memory-side req/ack bus of the data memory port; master is the port, slave is the memory.
interface data_mem_port_if #(
  parameter int ADDR_W = 32
) ();

  logic              MemReq;
  logic              MemWe;
  logic [ADDR_W-1:0] MemAddr;
  logic [3:0]        MemBe;
  logic [31:0]       MemWData;
  logic [31:0]       MemRData;
  logic              MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemBe, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemBe, MemWData,
    output MemRData, MemAck
  );

endinterface

// File: rtl/data_mem_port_lane_align.sv
// Byte-lane steering: byte enables, replicated store data, right-aligned load data
// and the misalignment/illegal-size flag for one access.
module lane_align
  import dmp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wData,
  input  logic [31:0] rData,
  output logic [3:0]  be,
  output logic [31:0] wDataRep,
  output logic [31:0] rDataAligned,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    be           = 4'b0000;
    wDataRep     = wData;
    rDataAligned = 32'h0;
    misalign     = 1'b0;
    shifted      = rData >> {offset, 3'b000};
    case (size)
      SIZE_BYTE: begin
        be           = 4'b0001 << offset;
        wDataRep     = {4{wData[7:0]}};
        rDataAligned = {24'h0, shifted[7:0]};
      end
      SIZE_HALF: begin
        be           = 4'b0011 << offset;
        wDataRep     = {2{wData[15:0]}};
        rDataAligned = {16'h0, shifted[15:0]};
        misalign     = offset[0];
      end
      SIZE_WORD: begin
        be           = 4'b1111;
        rDataAligned = shifted;
        misalign     = (offset != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Load/store port between datapath and data memory with a req/ack handshake.
// Optional `DMP_TIMEOUT_EN aborts an access to FAULT when MemAck never arrives.
module data_mem_port
  import dmp_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef DMP_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic              WriteEn,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       WriteData,
  output logic              Busy,
  output logic              Valid,
  output logic              Fault,
  output logic [31:0]       MemData,
  data_mem_port_if.master   mem
);

  dmpState_t         state, nextState;
  logic              wrEnQ;
  logic [1:0]        sizeQ;
  logic [ADDR_W-1:0] addrQ;
  logic [31:0]       wDataQ;
  logic [31:0]       memDataQ;

  logic [1:0]        alignSize;
  logic [1:0]        alignOffset;
  logic [3:0]        laneBe;
  logic [31:0]       laneWData;
  logic [31:0]       laneRData;
  logic              laneMisalign;

  logic              memReqNext;
  logic              memWeNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [3:0]        memBeNext;
  logic [31:0]       memWDataNext;

`ifdef DMP_TIMEOUT_EN
  logic [3:0]        waitCnt;
`endif

  // In IDLE the aligner judges the incoming request; afterwards it serves the captured one.
  assign alignSize   = (state == IDLE) ? Size      : sizeQ;
  assign alignOffset = (state == IDLE) ? Addr[1:0] : addrQ[1:0];

  lane_align uLaneAlign (
    .size         (alignSize),
    .offset       (alignOffset),
    .wData        (wDataQ),
    .rData        (mem.MemRData),
    .be           (laneBe),
    .wDataRep     (laneWData),
    .rDataAligned (laneRData),
    .misalign     (laneMisalign)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wrEnQ    <= 1'b0;
      sizeQ    <= 2'b00;
      addrQ    <= '0;
      wDataQ   <= 32'h0;
      memDataQ <= 32'h0;
`ifdef DMP_TIMEOUT_EN
      waitCnt  <= 4'd0;
`endif
    end else begin
      state <= nextState;
      if (state == IDLE && Req) begin
        wrEnQ  <= WriteEn;
        sizeQ  <= Size;
        addrQ  <= Addr;
        wDataQ <= WriteData;
      end
      if (state == REQ && mem.MemAck && !wrEnQ) begin
        memDataQ <= laneRData;
      end
`ifdef DMP_TIMEOUT_EN
      waitCnt <= (state == REQ) ? waitCnt + 4'd1 : 4'd0;
`endif
    end
  end

  always_comb begin
    nextState    = state;
    Busy         = (state != IDLE);
    Valid        = 1'b0;
    Fault        = 1'b0;
    memReqNext   = 1'b0;
    memWeNext    = 1'b0;
    memAddrNext  = '0;
    memBeNext    = 4'b0000;
    memWDataNext = 32'h0;
    case (state)
      IDLE: begin
        if (Req) begin
          nextState = laneMisalign ? FAULT : REQ;
        end
      end
      REQ: begin
        memReqNext   = 1'b1;
        memWeNext    = wrEnQ;
        memAddrNext  = {addrQ[ADDR_W-1:2], 2'b00};
        memBeNext    = laneBe;
        memWDataNext = laneWData;
        if (mem.MemAck) begin
          nextState = DONE;
`ifdef DMP_TIMEOUT_EN
        end else if (waitCnt == 4'(TIMEOUT - 1)) begin
          nextState = FAULT;
`endif
        end
      end
      DONE: begin
        Valid     = 1'b1;
        nextState = IDLE;
      end
      FAULT: begin
        Fault     = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign mem.MemReq   = memReqNext;
  assign mem.MemWe    = memWeNext;
  assign mem.MemAddr  = memAddrNext;
  assign mem.MemBe    = memBeNext;
  assign mem.MemWData = memWDataNext;
  assign MemData      = memDataQ;

endmodule
